sprite_blitter: RTL and testbench

Parametrised, positionable sprite renderer for the VGA pipeline: the successor to the full-screen stretched sprite, generalised to any sprite size, placed at a programmable position with power-of-two scaling. Each pixel is mapped to a sprite-ROM address and the returned colour index is registered. The block asserts a per-pixel hit flag that downstream palette and compositing logic uses for layering. Position, scale, fill and blink controls are shadow-latched once per frame, so software updates never tear mid-frame; these controls serve tank, health-bar and status-icon overlays.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_frame_ctrl.sv | 75 +++++++
 rtl/sprite_blitter.sv | 110 +++++++++++
 tb/tb_sprite_blitter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared screen constants and the per-frame sprite configuration record.
package sprite_pkg;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int COORD_W    = 10;
  localparam int SCOORD_W   = 11;
  localparam int CFG_FILL_W = 11;

  typedef struct packed {
    logic [COORD_W-1:0]    pos_x;
    logic [COORD_W-1:0]    pos_y;
    logic [1:0]            scale_sh;
    logic [CFG_FILL_W-1:0] fill;
    logic                  enable;
    logic                  blink_en;
  } sprite_cfg_t;
endpackage

// File: rtl/sprite_frame_ctrl.sv
// Frame-boundary shadow latch for sprite controls plus the blink frame counter.
module sprite_frame_ctrl
  import sprite_pkg::*;
#(
  parameter int SPR_W        = 32,
  parameter int FILL_W       = $clog2(SPR_W) + 1,
  parameter int VLATCH_LINE  = 480,
  parameter int BLINK_FRAMES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [1:0]         scale_sh,
  input  logic [FILL_W-1:0]  fill_level,
  input  logic               enable,
  input  logic               blink_en,
  output sprite_cfg_t        cfg,
  output logic               blink_hide
);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  sprite_cfg_t      cfg_d, cfg_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             phase_d, phase_q;
  logic             boundary;
  logic [FILL_W-1:0] fill_sat;

  assign boundary = (draw_x == '0) && (draw_y == COORD_W'(VLATCH_LINE));
  assign fill_sat = (fill_level > FILL_W'(SPR_W)) ? FILL_W'(SPR_W) : fill_level;

  always_comb begin
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (boundary) begin
      cfg_d.pos_x    = pos_x;
      cfg_d.pos_y    = pos_y;
      cfg_d.scale_sh = scale_sh;
      cfg_d.fill     = CFG_FILL_W'(fill_sat);
      cfg_d.enable   = enable;
      cfg_d.blink_en = blink_en;
    end
    // Counter is gated by the blink enable of the frame just ending, so the
    // first blinking frame always starts visible at count 0.
    if (!cfg_q.blink_en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (boundary) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign cfg        = cfg_q;
  assign blink_hide = cfg_q.blink_en && phase_q;
endmodule

// File: rtl/sprite_blitter.sv
// Positionable, power-of-two scaled sprite renderer: pixel -> ROM address,
// with hit/blank qualifiers carried two stages to line up with the ROM data.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W        = 32,
  parameter int SPR_H        = 32,
  parameter int IDX_W        = 8,
  parameter int ADDR_W       = $clog2(SPR_W * SPR_H),
  parameter int FILL_W       = $clog2(SPR_W) + 1,
  parameter int TRANSP_IDX   = 0,
  parameter int VLATCH_LINE  = 480,
  parameter int BLINK_FRAMES = 16
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               blank,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [1:0]         scale_sh,
  input  logic [FILL_W-1:0]  fill_level,
  input  logic               enable,
  input  logic               blink_en,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pix_idx,
  output logic               pix_hit,
  output logic               blank_out
);
  sprite_cfg_t cfg;
  logic        blink_hide;

  sprite_frame_ctrl #(
    .SPR_W       (SPR_W),
    .FILL_W      (FILL_W),
    .VLATCH_LINE (VLATCH_LINE),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_frame_ctrl (
    .clk       (vga_clk),
    .rst       (reset),
    .draw_x    (DrawX),
    .draw_y    (DrawY),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .scale_sh  (scale_sh),
    .fill_level(fill_level),
    .enable    (enable),
    .blink_en  (blink_en),
    .cfg       (cfg),
    .blink_hide(blink_hide)
  );

  logic signed [SCOORD_W-1:0] rx, ry;
  logic [15:0]        box_w, box_h;
  logic [COORD_W-1:0] sx, sy;
  logic               in_box, fill_ok, qual;

  logic [ADDR_W-1:0] rom_address_d, rom_address_q;
  logic [1:0]        hit_pipe_d, hit_pipe_q;
  logic [1:0]        blank_pipe_d, blank_pipe_q;
  logic [IDX_W-1:0]  pix_idx_d, pix_idx_q;
  logic              pix_hit_d, pix_hit_q;
  logic              blank_out_d, blank_out_q;

  always_comb begin
    rx    = $signed({1'b0, DrawX}) - $signed({1'b0, cfg.pos_x});
    ry    = $signed({1'b0, DrawY}) - $signed({1'b0, cfg.pos_y});
    box_w = 16'(SPR_W) << cfg.scale_sh;
    box_h = 16'(SPR_H) << cfg.scale_sh;
    // Sign bit clear means the low COORD_W bits hold the full offset.
    in_box = !rx[SCOORD_W-1] && !ry[SCOORD_W-1] &&
             (16'(rx[COORD_W-1:0]) < box_w) && (16'(ry[COORD_W-1:0]) < box_h);
    sx      = rx[COORD_W-1:0] >> cfg.scale_sh;
    sy      = ry[COORD_W-1:0] >> cfg.scale_sh;
    fill_ok = CFG_FILL_W'(sx) < cfg.fill;
    qual    = in_box && fill_ok && cfg.enable && !(cfg.blink_en && blink_hide) && blank;

    rom_address_d = in_box ? ADDR_W'(32'(sy) * SPR_W + 32'(sx)) : '0;
    hit_pipe_d    = {hit_pipe_q[0], qual};
    blank_pipe_d  = {blank_pipe_q[0], blank};
    pix_idx_d     = rom_q;
    pix_hit_d     = hit_pipe_q[1] && (rom_q != IDX_W'(TRANSP_IDX));
    blank_out_d   = blank_pipe_q[1];
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address_q <= '0;
      hit_pipe_q    <= '0;
      blank_pipe_q  <= '0;
      pix_idx_q     <= '0;
      pix_hit_q     <= 1'b0;
      blank_out_q   <= 1'b0;
    end else begin
      rom_address_q <= rom_address_d;
      hit_pipe_q    <= hit_pipe_d;
      blank_pipe_q  <= blank_pipe_d;
      pix_idx_q     <= pix_idx_d;
      pix_hit_q     <= pix_hit_d;
      blank_out_q   <= blank_out_d;
    end
  end

  assign rom_address = rom_address_q;
  assign pix_idx     = pix_idx_q;
  assign pix_hit     = pix_hit_q;
  assign blank_out   = blank_out_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a synchronous ROM model (data = addr[7:0]^0x5A).
module tb_sprite_blitter;
  logic       vga_clk;
  logic       reset;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic [9:0] pos_x, pos_y;
  logic [1:0] scale_sh;
  logic [5:0] fill_level;
  logic       enable, blink_en;
  logic [9:0] rom_address;
  logic [7:0] rom_q;
  logic [7:0] pix_idx;
  logic       pix_hit, blank_out;
  logic       transp;

  int total = 0;
  int bad   = 0;

  sprite_blitter #(.BLINK_FRAMES(2)) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .scale_sh(scale_sh), .fill_level(fill_level),
    .enable(enable), .blink_en(blink_en), .rom_address(rom_address), .rom_q(rom_q),
    .pix_idx(pix_idx), .pix_hit(pix_hit), .blank_out(blank_out)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= transp ? 8'h00 : (rom_address[7:0] ^ 8'h5A);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input bit b);
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
  endtask

  // Sample one pixel, then two blank filler pixels; check address at k,
  // unchanged outputs at k+1 and final outputs at k+2.
  task automatic probe(input string tag, input int x, input int y, input bit b,
                       input int exp_addr, input bit exp_hit, input int exp_idx);
    drive(x, y, b);
    @(posedge vga_clk); #1;
    if (exp_addr >= 0) chk({tag, ".addr"}, 32'(rom_address), 32'(exp_addr));
    drive(700, 600, 1'b0);
    @(posedge vga_clk); #1;
    chk({tag, ".lat"}, 32'(pix_hit), 32'd0);
    @(posedge vga_clk); #1;
    chk({tag, ".hit"}, 32'(pix_hit), 32'(exp_hit));
    chk({tag, ".blank"}, 32'(blank_out), 32'(b));
    if (exp_idx >= 0) chk({tag, ".idx"}, 32'(pix_idx), 32'(exp_idx));
  endtask

  task automatic frame();
    drive(0, 480, 1'b0);
    drive(700, 600, 1'b0);
    @(posedge vga_clk);
    @(posedge vga_clk);
  endtask

  initial begin
    reset = 1'b1; transp = 1'b0;
    DrawX = 10'd700; DrawY = 10'd600; blank = 1'b0;
    pos_x = 10'd100; pos_y = 10'd50; scale_sh = 2'd0; fill_level = 6'd32;
    enable = 1'b1; blink_en = 1'b0;
    #1;
    chk("rst.addr", 32'(rom_address), 32'd0);
    chk("rst.hit", 32'(pix_hit), 32'd0);
    chk("rst.idx", 32'(pix_idx), 32'd0);
    chk("rst.blank", 32'(blank_out), 32'd0);
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk) reset = 1'b0;
    repeat (3) @(posedge vga_clk);

    probe("pre_boundary", 100, 50, 1, 0, 0, -1);
    frame();
    probe("tl", 100, 50, 1, 0, 1, 8'h5A);
    probe("br", 131, 81, 1, 1023, 1, 8'hA5);
    probe("left_out", 99, 50, 1, 0, 0, -1);
    probe("right_out", 132, 60, 1, 0, 0, -1);
    probe("below_out", 100, 82, 1, 0, 0, -1);
    probe("blanked", 110, 60, 0, 330, 0, -1);

    pos_x = 10'd0; pos_y = 10'd0; scale_sh = 2'd2;
    frame();
    probe("sc_x0", 0, 0, 1, 0, 1, 8'h5A);
    probe("sc_x3", 3, 0, 1, 0, 1, -1);
    probe("sc_x4", 4, 0, 1, 1, 1, 8'h5B);
    probe("sc_x127", 127, 0, 1, 31, 1, 8'h45);
    probe("sc_x128", 128, 0, 1, 0, 0, -1);
    probe("sc_br", 127, 127, 1, 1023, 1, 8'hA5);

    pos_x = 10'd100; pos_y = 10'd50; scale_sh = 2'd0; fill_level = 6'd10;
    frame();
    probe("fill10_in", 109, 50, 1, 9, 1, 8'h53);
    probe("fill10_out", 110, 50, 1, 10, 0, -1);
    fill_level = 6'd40;
    frame();
    probe("fill40_edge", 131, 50, 1, 31, 1, 8'h45);
    transp = 1'b1;
    probe("transp", 105, 50, 1, 5, 0, 0);
    transp = 1'b0;
    fill_level = 6'd0;
    frame();
    probe("fill0", 100, 50, 1, 0, 0, -1);

    fill_level = 6'd32;
    frame();
    pos_x = 10'd200;
    probe("tear_old", 100, 50, 1, 0, 1, -1);
    probe("tear_new_early", 200, 50, 1, 0, 0, -1);
    frame();
    probe("tear_new", 200, 50, 1, 0, 1, -1);
    probe("tear_old_gone", 100, 50, 1, 0, 0, -1);

    pos_x = 10'd620; pos_y = 10'd470;
    frame();
    probe("clip_tl", 620, 470, 1, 0, 1, 8'h5A);
    probe("clip_last", 639, 479, 1, 307, 1, 8'h69);
    probe("clip_offscr", 640, 479, 0, 308, 0, -1);
    probe("clip_neg", 10, 475, 1, 0, 0, -1);

    pos_x = 10'd100; pos_y = 10'd50; blink_en = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      frame();
      probe($sformatf("blink_f%0d", f), 100, 50, 1, 0, (f == 3 || f == 4) ? 1'b0 : 1'b1, -1);
    end
    blink_en = 1'b0;
    for (int f = 6; f <= 7; f++) begin
      frame();
      probe($sformatf("noblink_f%0d", f), 100, 50, 1, 0, 1, -1);
    end

    drive(105, 55, 1'b1);
    repeat (3) @(posedge vga_clk);
    #1 chk("mid.hit_before", 32'(pix_hit), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid.rst_hit", 32'(pix_hit), 32'd0);
    chk("mid.rst_addr", 32'(rom_address), 32'd0);
    chk("mid.rst_idx", 32'(pix_idx), 32'd0);
    chk("mid.rst_blank", 32'(blank_out), 32'd0);
    @(negedge vga_clk) reset = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1 chk("mid.after_release", 32'(pix_hit), 32'd0);
    frame();
    probe("mid.after_boundary", 105, 55, 1, 165, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
